mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one single-ported memory bus between two requesters: instruction fetch (m0, read-only) and the execute-stage load/store path (m1, read/write).
- Allows one outstanding transaction at a time. m1 has fixed priority, and a starvation counter guarantees that fetch makes progress.
- Drives hold_flag_o into ctrl so the pipeline stalls while a data access is pending.
- Sits between ifetch/ex and the shared ROM/RAM bus.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_WAIT, 4, number of consecutive m0 losses after which m0 wins the next arbitration.
- TIMEOUT, 16, number of cycles in WAIT without s_rvalid_i before the transaction is aborted with an error.

Ports:
- clk  in  1  clock. One clock domain only; all logic is on the rising edge.
- rst  in  1  reset. Asynchronous, active-low.
- m0_req_i  in  1  fetch request. Held until m0_gnt_o.
- m0_addr_i  in  ADDR_W  fetch address.
- m0_gnt_o  out  1  fetch request accepted by the slave.
- m0_rvalid_o  out  1  fetch response valid (one-cycle pulse).
- m0_err_o  out  1  fetch timeout (one-cycle pulse, coincident with m0_rvalid_o).
- m1_req_i  in  1  data request. Held until m1_gnt_o.
- m1_we_i  in  1  1 = store, 0 = load.
- m1_addr_i  in  ADDR_W  data address.
- m1_wdata_i  in  DATA_W  store data.
- m1_be_i  in  4  byte enables.
- m1_gnt_o  out  1  data request accepted by the slave.
- m1_rvalid_o  out  1  data response valid (pulse; also asserted for stores).
- m1_err_o  out  1  data timeout (pulse).
- rdata_o  out  DATA_W  response data. Shared by both masters; qualify with m*_rvalid_o.
- s_req_o  out  1  bus request.
- s_we_o  out  1  bus write enable.
- s_addr_o  out  ADDR_W  bus address.
- s_wdata_o  out  DATA_W  bus write data.
- s_be_o  out  4  bus byte enables.
- s_ready_i  in  1  slave accepts the request this cycle.
- s_rvalid_i  in  1  slave response valid.
- s_rdata_i  in  DATA_W  slave read data.
- hold_flag_o  out  1  stall request to ctrl.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=0, starve_cnt=0, tmo_cnt=0.
  - All registered outputs are 0, including rdata_o.
  - An in-flight transaction is dropped. A late s_rvalid_i arriving after reset is ignored.
- FSM states: IDLE, WAIT.
- IDLE:
  - Winner selection: m0 wins if m0_req_i and (!m1_req_i or starve_cnt==MAX_WAIT). Otherwise m1 wins if m1_req_i.
  - s_req_o and s_we/addr/wdata/be are driven combinationally from the winner. For m0, s_we_o=0 and s_be_o=4'hF.
  - If there is no request, s_req_o=0 and s_* are 0.
  - When s_ready_i=1 and s_req_o=1:
    - the winner's m*_gnt_o is high in the same cycle;
    - owner<=winner, tmo_cnt<=0, state<=WAIT.
  - The loser's gnt stays 0.
  - s_rvalid_i in IDLE is ignored.
- starve_cnt:
  - Increments (saturating at MAX_WAIT) when m1 is granted while m0_req_i=1.
  - Clears when m0 is granted.
  - Unchanged otherwise.
- WAIT:
  - s_req_o=0 and no grants are issued.
  - tmo_cnt increments each cycle.
  - On s_rvalid_i:
    - rdata_o<=s_rdata_i;
    - owner's m*_rvalid_o pulses 1 on the next cycle (registered, latency 1 after s_rvalid_i);
    - state<=IDLE.
  - If tmo_cnt reaches TIMEOUT-1 with no s_rvalid_i:
    - rdata_o<=0;
    - owner's m*_rvalid_o and m*_err_o pulse together;
    - state<=IDLE.
  - If s_rvalid_i coincides with the timeout cycle, the valid response wins and err=0.
- Throughput: minimum transaction is 2 cycles (grant, then response). The next arbitration happens in the cycle after the return to IDLE.
- hold_flag_o (combinational) = (m1_req_i and !m1_gnt_o) or (state==WAIT and owner==m1).
  - It is low in the cycle of m1_rvalid_o.
- Masters must keep req/addr/data stable until gnt. Dropping req before gnt is legal; that master is simply not served.

Test Plan:
- Lone fetch: m0_req, addr 0x100, s_ready=1, s_rvalid one cycle later with 0xDEADBEEF -> m0_gnt in cycle 0, m0_rvalid and rdata_o=0xDEADBEEF in cycle 2, hold_flag_o=0 throughout.
- Simultaneous requests: m0 addr 0x10, m1 load addr 0x2000 -> m1 granted first (s_addr_o=0x2000), hold_flag_o=1 until m1_rvalid, m0 granted next with s_addr_o=0x10, starve_cnt returns to 0.
- Starvation: m0 and m1 both request continuously, MAX_WAIT=4 -> m1 is granted 4 times, then m0 on the 5th arbitration, then m1 again.
- Store: m1_we=1, addr 0x40, wdata 0x12345678, be 4'b0011 -> s_we_o=1, s_be_o=0011, s_wdata_o=0x12345678; m1_rvalid pulses after s_rvalid.
- Timeout: grant m1, never assert s_rvalid, TIMEOUT=16 -> m1_rvalid=m1_err=1 with rdata_o=0 exactly 16 cycles after grant; FSM returns to IDLE and then serves a pending m0. Separately, s_rvalid in the timeout cycle -> err=0.
- Reset mid-WAIT: rst low while owner=m1 -> all outputs 0 immediately. A stale s_rvalid after rst releases produces no m*_rvalid_o.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one single-ported memory bus between instruction fetch (m0,
// read-only) and the execute-stage load/store path (m1, read/write).
// Only one transaction is outstanding at a time. m1 has fixed priority,
// but after MAX_WAIT consecutive losses m0 wins the next arbitration.
// A transaction that receives no response aborts with an error pulse.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   m0_req_i/addr_i     fetch request (held until m0_gnt_o)
//   m0_gnt_o            fetch accepted by the slave this cycle
//   m0_rvalid_o/err_o   fetch response / timeout pulse (registered)
//   m1_req_i/we_i/addr_i/wdata_i/be_i   data request (held until m1_gnt_o)
//   m1_gnt_o            data accepted by the slave this cycle
//   m1_rvalid_o/err_o   data response / timeout pulse (registered)
//   rdata_o             response data shared by both masters
//   s_req_o/we_o/addr_o/wdata_o/be_o    request side of the shared bus
//   s_ready_i           slave accepts the request this cycle
//   s_rvalid_i/rdata_i  slave response
//   hold_flag_o         pipeline stall while a data access is pending
module mem_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic [3:0]        m1_be_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic              m1_err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  output logic [3:0]        s_be_o,
  input  logic              s_ready_i,
  input  logic              s_rvalid_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  output logic              hold_flag_o
);

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
  // tmo_cnt is 0 in the first WAIT cycle; the abort fires in the cycle whose
  // increment would bring the counter to TIMEOUT-1, so the error pulse lands
  // exactly TIMEOUT cycles after the grant.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q;      // 0 = m0, 1 = m1
  logic [SW-1:0]   starve_cnt;
  logic [TW-1:0]   tmo_cnt;

  logic            pick_m0;
  logic            pick_m1;
  logic            accept;
  logic            tmo_hit;

  // Winner selection: m1 wins unless m0 has been starved long enough.
  assign pick_m0 = m0_req_i && (!m1_req_i || (starve_cnt == STARVE_MAX));
  assign pick_m1 = !pick_m0 && m1_req_i;
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Bus request muxing, grants and next state.
  always_comb begin
    state_d   = state_q;
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_be_o    = 4'h0;
    m0_gnt_o  = 1'b0;
    m1_gnt_o  = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_m0) begin
          s_req_o  = 1'b1;
          s_addr_o = m0_addr_i;
          s_be_o   = 4'hF;
        end else if (pick_m1) begin
          s_req_o   = 1'b1;
          s_we_o    = m1_we_i;
          s_addr_o  = m1_addr_i;
          s_wdata_o = m1_wdata_i;
          s_be_o    = m1_be_i;
        end
        accept   = s_req_o && s_ready_i;
        m0_gnt_o = accept && pick_m0;
        m1_gnt_o = accept && pick_m1;
        if (accept) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (s_rvalid_i || tmo_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall the pipeline while a data request waits for a grant or a response.
  assign hold_flag_o = (m1_req_i && !m1_gnt_o) || ((state_q == ST_WAIT) && owner_q);

  // State, counters and the registered response outputs. A valid response
  // in the timeout cycle takes precedence over the abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      starve_cnt  <= '0;
      tmo_cnt     <= '0;
      rdata_o     <= '0;
      m0_rvalid_o <= 1'b0;
      m0_err_o    <= 1'b0;
      m1_rvalid_o <= 1'b0;
      m1_err_o    <= 1'b0;
    end else begin
      state_q     <= state_d;
      m0_rvalid_o <= 1'b0;
      m0_err_o    <= 1'b0;
      m1_rvalid_o <= 1'b0;
      m1_err_o    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= pick_m1;
            tmo_cnt <= '0;
          end
          if (m0_gnt_o) begin
            starve_cnt <= '0;
          end else if (m1_gnt_o && m0_req_i && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
        end
        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (s_rvalid_i) begin
            rdata_o <= s_rdata_i;
            if (owner_q) m1_rvalid_o <= 1'b1;
            else         m0_rvalid_o <= 1'b1;
          end else if (tmo_hit) begin
            rdata_o <= '0;
            if (owner_q) begin
              m1_rvalid_o <= 1'b1;
              m1_err_o    <= 1'b1;
            end else begin
              m0_rvalid_o <= 1'b1;
              m0_err_o    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
